if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter NOP_INSTR, 32'h00000013, instruction presented on o_instr whenever o_valid is 0 (addi x0,x0,0).
REQ-002 Parameter RESET_PC, 32'h00000000, value of o_PC while in reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  rising-edge clock shared with the fetch stage.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_PC  input  32  current fetch PC from the fetch stage, i.e. the address presented to instruction memory this cycle.
REQ-007 i_inc_pc  input  32  i_PC + 4 from the fetch stage.
REQ-008 i_imem_rdata  input  32  synchronous instruction-memory read data; valid one cycle after its address; not guaranteed stable while stalled.
REQ-009 i_stall  input  1  decode-side hazard stall; hold the current decode contents.
REQ-010 i_flush  input  1  branch/jump redirect; squash the instruction entering decode.
REQ-011 o_PC  output  32  PC of the instruction in decode.
REQ-012 o_inc_pc  output  32  o_PC + 4, as captured.
REQ-013 o_instr  output  32  instruction in decode.
REQ-014 o_valid  output  1  o_instr is a real instruction.

Function
REQ-015 The FSM SHALL have three states: BUBBLE (o_valid=0), RUN (o_valid=1, o_instr = i_imem_rdata), HOLD (o_valid=1, o_instr = hold register).
REQ-016 Each rising edge SHALL apply priority flush > stall > advance.
REQ-017 On flush from any state: capture i_PC/i_inc_pc, clear the hold register valid flag, next state BUBBLE.
REQ-018 On stall with no flush: o_PC/o_inc_pc SHALL be unchanged.
- RUN -> HOLD, capturing i_imem_rdata into the hold register.
- HOLD -> HOLD, hold register unchanged.
- BUBBLE -> BUBBLE.
REQ-019 On advance (no flush, no stall): capture i_PC/i_inc_pc, next state RUN from any state.
REQ-020 o_instr SHALL be combinational: NOP_INSTR in BUBBLE, i_imem_rdata in RUN, hold register in HOLD; o_valid SHALL be registered (state != BUBBLE).
REQ-021 Latency: an address on i_PC at edge n SHALL appear on o_PC with its instruction on o_instr from edge n+1 until the next advance or flush.
REQ-022 When flush and stall are simultaneous, flush SHALL win and the stall SHALL be ignored for that edge.
REQ-023 An instruction held through N stall cycles (N>=1) SHALL be presented unchanged for N+1 cycles, regardless of i_imem_rdata activity.
REQ-024 No arithmetic is performed; o_inc_pc SHALL be the captured i_inc_pc, never recomputed.

Reset
REQ-025 On i_rst assertion, immediately and independent of i_clk: state BUBBLE, o_valid=0, o_PC=RESET_PC, o_inc_pc=RESET_PC+4, hold register=NOP_INSTR, o_instr=NOP_INSTR.
REQ-026 Reset asserted mid-HOLD SHALL discard the held instruction.
REQ-027 At the first edge after reset release with no stall/flush, the state SHALL move to RUN.

Structure
REQ-028 NOP_INSTR, RESET_PC and the state encoding (BUBBLE=2'd0, RUN=2'd1, HOLD=2'd2) SHALL live in the shared pipeline constants package, reused by the ID/EX and later stage registers.
REQ-029 The block SHALL be a single flat module with no sub-modules; the hold register and FSM are local.

Verification
REQ-030 Reset then release, i_PC=0x0, 0x4, 0x8 with rdata 0x00500093, 0x00A00113, 0x002081B3 one cycle later -> o_valid=0 during reset; then o_PC/o_instr pairs 0x0/0x00500093, 0x4/0x00A00113 on consecutive cycles.
REQ-031 Stall 3 cycles while in RUN with o_PC=0x4/0x00A00113, rdata driven to 0xDEADBEEF -> o_PC=0x4 and o_instr=0x00A00113 for 4 cycles; advance resumes with 0x8.
REQ-032 Flush at o_PC=0x8 -> next cycle o_valid=0, o_instr=0x00000013; following advance gives o_valid=1 with the redirected PC, e.g. 0x40.
REQ-033 Simultaneous i_flush=1 and i_stall=1 while in HOLD -> next state BUBBLE, o_valid=0, hold register discarded.
REQ-034 i_rst pulsed asynchronously mid-clock while in HOLD -> outputs reach their reset values before the next edge; after release, no stale held instruction appears.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared pipeline constants: the bubble instruction, the reset PC and the
// encoding of the stage-register occupancy FSM. The ID/EX and later stage
// registers import this package too.
package if_id_reg_pkg;

  // addi x0,x0,0 -- the canonical RISC-V no-op inserted as a bubble
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

  // PC presented by a stage register while it is held in reset
  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;

  // Stage-register occupancy: empty, live from memory, or frozen copy
  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } pipe_state_e;

endpackage : if_id_reg_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. The instruction memory is synchronous, so the
// instruction belonging to the captured PC only arrives one cycle later and
// is forwarded combinationally in RUN. When decode stalls, that data is no
// longer guaranteed stable, so the first stall edge snapshots it into a
// local hold register that feeds o_instr for the rest of the stall.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR,
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_PC,
  input  logic [31:0] i_inc_pc,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_PC,
  output logic [31:0] o_inc_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  pipe_state_e state_r;
  pipe_state_e state_nxt;

  logic [31:0] pc_r;
  logic [31:0] inc_pc_r;
  logic [31:0] hold_instr_r;
  logic        hold_valid_r;
  logic        valid_r;

  logic        capture_pc_s;
  logic        capture_hold_s;
  logic        clear_hold_s;

  // FSM state register; reset drops any in-flight or held instruction
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_BUBBLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next state with priority flush > stall > advance
  always_comb begin
    state_nxt = state_r;
    if (i_flush) begin
      state_nxt = ST_BUBBLE;
    end else if (i_stall) begin
      case (state_r)
        ST_BUBBLE: state_nxt = ST_BUBBLE;
        ST_RUN:    state_nxt = ST_HOLD;
        ST_HOLD:   state_nxt = ST_HOLD;
        default:   state_nxt = ST_BUBBLE;
      endcase
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // FSM outputs: capture strobes and the instruction source for decode
  always_comb begin
    capture_pc_s   = 1'b0;
    capture_hold_s = 1'b0;
    clear_hold_s   = 1'b0;
    o_instr        = NOP_INSTR;
    if (i_flush) begin
      capture_pc_s = 1'b1;
      clear_hold_s = 1'b1;
    end else if (i_stall) begin
      capture_hold_s = (state_r == ST_RUN);
    end else begin
      capture_pc_s = 1'b1;
      clear_hold_s = 1'b1;
    end
    case (state_r)
      ST_BUBBLE: o_instr = NOP_INSTR;
      ST_RUN:    o_instr = i_imem_rdata;
      ST_HOLD:   o_instr = hold_valid_r ? hold_instr_r : NOP_INSTR;
      default:   o_instr = NOP_INSTR;
    endcase
  end

  // Registered valid flag, updated in lockstep with the state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= (state_nxt != ST_BUBBLE);
    end
  end

  // PC pair of the decode slot; the incremented PC is captured, never recomputed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_r     <= RESET_PC;
      inc_pc_r <= RESET_PC + 32'd4;
    end else if (capture_pc_s) begin
      pc_r     <= i_PC;
      inc_pc_r <= i_inc_pc;
    end else begin
      pc_r     <= pc_r;
      inc_pc_r <= inc_pc_r;
    end
  end

  // Hold register: snapshot memory data on the first stall edge out of RUN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_instr_r <= NOP_INSTR;
      hold_valid_r <= 1'b0;
    end else if (capture_hold_s) begin
      hold_instr_r <= i_imem_rdata;
      hold_valid_r <= 1'b1;
    end else if (clear_hold_s) begin
      hold_instr_r <= hold_instr_r;
      hold_valid_r <= 1'b0;
    end else begin
      hold_instr_r <= hold_instr_r;
      hold_valid_r <= hold_valid_r;
    end
  end

  assign o_PC     = pc_r;
  assign o_inc_pc = inc_pc_r;
  assign o_valid  = valid_r;

endmodule : if_id_reg

// File: tb/tb_if_id_reg.sv
// Directed scoreboard bench for if_id_reg. The driver applies one row per
// cycle just after the rising edge and pushes the hand-computed outputs for
// that cycle; a separate monitor pops and compares on the falling edge or
// on an explicit mid-cycle sample request (used around the async reset).
module tb_if_id_reg;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_PC;
  logic [31:0] i_inc_pc;
  logic [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] o_PC;
  logic [31:0] o_inc_pc;
  logic [31:0] o_instr;
  logic        o_valid;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  typedef struct {
    int          tag;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] rdata;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
  } row_t;

  exp_t sb_q[$];
  row_t rows[$];
  int   total = 0;
  int   bad   = 0;
  event sample_ev;

  if_id_reg dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_PC         (i_PC),
    .i_inc_pc     (i_inc_pc),
    .i_imem_rdata (i_imem_rdata),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .o_PC         (o_PC),
    .o_inc_pc     (o_inc_pc),
    .o_instr      (o_instr),
    .o_valid      (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic add_row(input logic rst, input logic [31:0] pc, input logic stall,
                         input logic flush, input logic [31:0] rdata,
                         input logic ev, input logic [31:0] epc, input logic [31:0] ein);
    row_t r;
    r.rst = rst; r.pc = pc; r.stall = stall; r.flush = flush; r.rdata = rdata;
    r.ev = ev; r.epc = epc; r.ein = ein;
    rows.push_back(r);
  endtask

  task automatic push_exp(input int tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = pc; e.inc = pc + 32'd4; e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk or sample_ev);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (o_valid !== e.valid || o_PC !== e.pc || o_inc_pc !== e.inc || o_instr !== e.instr) begin
          bad++;
          $display("FAIL row%0d: got valid=%0b pc=%h inc=%h instr=%h, want valid=%0b pc=%h inc=%h instr=%h",
                   e.tag, o_valid, o_PC, o_inc_pc, o_instr, e.valid, e.pc, e.inc, e.instr);
        end
      end
    end
  end

  // Driver: directed rows, then an async reset pulse in the middle of HOLD
  initial begin
    int waited;
    i_rst = 1'b1; i_PC = 32'd0; i_inc_pc = 32'd4; i_imem_rdata = 32'd0;
    i_stall = 1'b0; i_flush = 1'b0;

    //      rst   pc          stall flush rdata          ev    epc         ein
    add_row(1'b1, 32'h0,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,      NOP);           // 0 in reset
    add_row(1'b0, 32'h0,      1'b0, 1'b0, 32'h0,         1'b0, 32'h0,      NOP);           // 1 released
    add_row(1'b0, 32'h4,      1'b0, 1'b0, 32'h00500093,  1'b1, 32'h0,      32'h00500093);  // 2
    add_row(1'b0, 32'h8,      1'b1, 1'b0, 32'h00A00113,  1'b1, 32'h4,      32'h00A00113);  // 3 stall from RUN
    add_row(1'b0, 32'h8,      1'b1, 1'b0, BAD,           1'b1, 32'h4,      32'h00A00113);  // 4 HOLD
    add_row(1'b0, 32'h8,      1'b1, 1'b0, BAD,           1'b1, 32'h4,      32'h00A00113);  // 5 HOLD
    add_row(1'b0, 32'h8,      1'b0, 1'b0, BAD,           1'b1, 32'h4,      32'h00A00113);  // 6 HOLD, 4th cycle
    add_row(1'b0, 32'hC,      1'b0, 1'b1, 32'h002081B3,  1'b1, 32'h8,      32'h002081B3);  // 7 flush at 0x8
    add_row(1'b0, 32'h40,     1'b0, 1'b0, 32'h12345678,  1'b0, 32'hC,      NOP);           // 8 bubble
    add_row(1'b0, 32'h44,     1'b0, 1'b0, 32'h00100513,  1'b1, 32'h40,     32'h00100513);  // 9 redirected
    add_row(1'b0, 32'h48,     1'b1, 1'b0, 32'h00200593,  1'b1, 32'h44,     32'h00200593);  // 10 stall
    add_row(1'b0, 32'h48,     1'b1, 1'b1, BAD,           1'b1, 32'h44,     32'h00200593);  // 11 HOLD, flush+stall
    add_row(1'b0, 32'h80,     1'b1, 1'b0, 32'hCAFEF00D,  1'b0, 32'h48,     NOP);           // 12 bubble, stall
    add_row(1'b0, 32'h80,     1'b0, 1'b0, 32'hCAFEF00D,  1'b0, 32'h48,     NOP);           // 13 bubble kept pc
    add_row(1'b0, 32'h84,     1'b1, 1'b0, 32'h00300613,  1'b1, 32'h80,     32'h00300613);  // 14 stall
    add_row(1'b0, 32'h84,     1'b1, 1'b0, BAD,           1'b1, 32'h80,     32'h00300613);  // 15 HOLD

    foreach (rows[k]) begin
      @(posedge i_clk);
      #1;
      i_rst        = rows[k].rst;
      i_PC         = rows[k].pc;
      i_inc_pc     = rows[k].pc + 32'd4;
      i_stall      = rows[k].stall;
      i_flush      = rows[k].flush;
      i_imem_rdata = rows[k].rdata;
      push_exp(k, rows[k].ev, rows[k].epc, rows[k].ein);
    end

    // Mid-cycle reset while holding 0x00300613 at 0x80
    @(negedge i_clk);
    #2;
    i_rst   = 1'b1;
    i_stall = 1'b0;
    i_PC    = 32'h100;
    i_inc_pc = 32'h104;
    #1;
    push_exp(100, 1'b0, 32'h0, NOP);
    -> sample_ev;
    #1;
    i_rst = 1'b0;

    // First edge after release advances to RUN with fresh data only
    @(posedge i_clk);
    #1;
    i_PC = 32'h104; i_inc_pc = 32'h108; i_imem_rdata = 32'h00400693;
    push_exp(101, 1'b1, 32'h100, 32'h00400693);
    @(posedge i_clk);
    #1;
    i_PC = 32'h108; i_inc_pc = 32'h10C; i_imem_rdata = 32'h00500713;
    push_exp(102, 1'b1, 32'h104, 32'h00500713);

    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge i_clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_reg
